// File: rtl/peripheral_divider.sv
// peripheral_divider: memory-mapped 32-bit unsigned restoring divider, 32-cycle fixed latency.
module peripheral_divider #(
  parameter int clk_freq = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);
  localparam int unused_clk_freq = clk_freq;
  typedef enum logic {IDLE, RUN} state_e;
  state_e      state_q;
  logic [31:0] a_q, b_q, q_q, r_q, wq_q, wd_q, pr_q, d_out_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q;
  logic        wr_en, rd_en, start;
  logic [32:0] t_d;
  logic [31:0] pr_d, wq_d, rdata_d;
  assign wr_en = cs & wr;
  assign rd_en = cs & rd;
  assign start = wr_en && addr == 3'd2 && d_in[0] && state_q == IDLE;
  // A negative trial difference means the divisor did not fit: restore the shifted remainder.
  assign t_d  = {pr_q, wq_q[31]} - {1'b0, wd_q};
  assign pr_d = t_d[32] ? {pr_q[30:0], wq_q[31]} : t_d[31:0];
  assign wq_d = {wq_q[30:0], ~t_d[32]};
  always_comb begin
    rdata_d = 32'd0;
    case (addr)
      3'd0: rdata_d = a_q;
      3'd1: rdata_d = b_q;
      3'd3: rdata_d = q_q;
      3'd4: rdata_d = r_q;
      3'd5: rdata_d = {30'd0, busy_q, done_q};
      default: rdata_d = 32'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      wq_q    <= '0;
      wd_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_out_q <= '0;
    end else begin
      if (rd_en) d_out_q <= rdata_d;
      if (wr_en && addr == 3'd0) a_q <= d_in;
      if (wr_en && addr == 3'd1) b_q <= d_in;
      case (state_q)
        IDLE: if (start) begin
          wq_q    <= a_q;
          wd_q    <= b_q;
          pr_q    <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          wq_q  <= wq_d;
          pr_q  <= pr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            q_q     <= wq_d;
            r_q     <= pr_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign d_out = d_out_q;
endmodule

// File: tb/tb_peripheral_divider.sv
// tb_peripheral_divider: arithmetic model compared every cycle plus literal read expectations.
module tb_peripheral_divider;
  logic        clk = 1'b0, resetn = 1'b0, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] d_in = 32'd0;
  logic [31:0] d_out;
  logic [31:0] ma = 0, mb = 0, mq = 0, mr = 0, pa = 0, pb = 0, md = 0;
  logic        mbusy = 0, mdone = 0, mvalid = 0;
  int          mleft = 0;
  logic        lit_req = 0, lit_armed = 0;
  logic [31:0] lit_exp = 0, lit_val = 0;
  string       lit_name = "", lit_nm = "";
  int          checks = 0, errors = 0;

  peripheral_divider #(.clk_freq(25000000)) dut (
    .clk(clk), .resetn(resetn), .d_in(d_in), .cs(cs),
    .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mreg(input logic [2:0] a);
    case (a)
      3'd0: return ma;
      3'd1: return mb;
      3'd3: return mq;
      3'd4: return mr;
      3'd5: return {30'd0, mbusy, mdone};
      default: return 32'd0;
    endcase
  endfunction

  // Model: a started division resolves to A/B, A%B (B=0 gives all-ones, A) 32 edges later.
  always @(posedge clk) begin
    mvalid    <= 1'b1;
    lit_armed <= cs && rd && lit_req;
    lit_val   <= lit_exp;
    lit_nm    <= lit_name;
    if (!resetn) begin
      ma <= 0; mb <= 0; mq <= 0; mr <= 0; md <= 0;
      mbusy <= 0; mdone <= 0; mleft <= 0;
    end else begin
      if (cs && rd) md <= mreg(addr);
      if (cs && wr && addr == 3'd0) ma <= d_in;
      if (cs && wr && addr == 3'd1) mb <= d_in;
      if (cs && wr && addr == 3'd2 && d_in[0] && !mbusy) begin
        pa <= ma; pb <= mb; mbusy <= 1; mdone <= 0; mleft <= 32;
      end
      if (mbusy) begin
        mleft <= mleft - 1;
        if (mleft == 1) begin
          mq <= (pb == 0) ? 32'hFFFF_FFFF : pa / pb;
          mr <= (pb == 0) ? pa : pa % pb;
          mbusy <= 0;
          mdone <= 1;
        end
      end
    end
  end

  always @(negedge clk) if (mvalid) begin
    checks++;
    if (d_out !== md) begin
      errors++;
      $display("FAIL model_dout t=%0t got %h want %h", $time, d_out, md);
    end
    if (lit_armed) begin
      checks++;
      if (d_out !== lit_val) begin
        errors++;
        $display("FAIL %s got %h want %h", lit_nm, d_out, lit_val);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] v);
    cs = 1; wr = 1; addr = a; d_in = v;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] e, input string nm);
    cs = 1; rd = 1; addr = a; lit_req = 1; lit_exp = e; lit_name = nm;
    @(negedge clk);
    cs = 0; rd = 0; lit_req = 0;
  endtask

  task automatic div(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input string nm);
    wr_reg(0, a);
    wr_reg(1, b);
    wr_reg(2, 1);
    idle(33);
    rd_chk(3, q, {nm, "_q"});
    rd_chk(4, r, {nm, "_r"});
  endtask

  initial begin
    @(negedge clk);
    idle(2);
    resetn = 1;
    rd_chk(5, 0, "rst_status");
    rd_chk(3, 0, "rst_q");
    rd_chk(4, 0, "rst_r");
    wr_reg(0, 100);
    wr_reg(1, 7);
    wr_reg(2, 1);
    rd_chk(5, 2, "busy_first");
    idle(30);
    rd_chk(5, 2, "busy_last");
    rd_chk(5, 1, "done_after");
    rd_chk(3, 14, "q_100_7");
    rd_chk(4, 2, "r_100_7");
    div(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, "max_by_1");
    div(5, 9, 0, 5, "small_by_big");
    div(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, "msb_by_max");
    div(1234, 0, 32'hFFFF_FFFF, 1234, "div_zero");
    rd_chk(5, 1, "div_zero_done");
    wr_reg(2, 2);
    rd_chk(5, 1, "init0_ignored");
    wr_reg(0, 1000);
    wr_reg(1, 10);
    wr_reg(2, 1);
    idle(4);
    wr_reg(0, 7);
    wr_reg(1, 2);
    wr_reg(2, 1);
    idle(24);
    rd_chk(5, 2, "busy_n32");
    rd_chk(3, 100, "q_1000_10");
    rd_chk(4, 0, "r_1000_10");
    rd_chk(0, 7, "a_readback");
    rd_chk(1, 2, "b_readback");
    rd_chk(2, 0, "init_read0");
    wr_reg(2, 1);
    idle(33);
    rd_chk(3, 3, "q_7_2");
    rd_chk(4, 1, "r_7_2");
    cs = 1; rd = 1; wr = 1; addr = 0; d_in = 55;
    lit_req = 1; lit_exp = 7; lit_name = "rw_pre_value";
    @(negedge clk);
    cs = 0; rd = 0; wr = 0; lit_req = 0;
    rd_chk(0, 55, "rw_written");
    wr_reg(6, 123);
    rd_chk(6, 0, "unused6");
    rd_chk(7, 0, "unused7");
    wr_reg(0, 50);
    wr_reg(1, 3);
    wr_reg(2, 1);
    idle(9);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    rd_chk(0, 0, "abort_a");
    rd_chk(1, 0, "abort_b");
    rd_chk(5, 0, "abort_status");
    idle(40);
    rd_chk(3, 0, "abort_q");
    rd_chk(4, 0, "abort_r");
    rd_chk(5, 0, "abort_status_late");
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
